// File: rtl/line_buffer_controller.sv
// Write/read-enable and coordinate sequencer for a line-FIFO window memory.
// Walks one frame raster-order and flags pixels where a full square window is available.
module line_buffer_controller #(
    parameter int FRAME_WIDTH          = 10,
    parameter int FRAME_HEIGHT         = 10,
    parameter int FIFO_COMPONENT_COUNT = 6,
    parameter int ADDR_WIDTH           = 4,
    parameter int BYTE_DOUBLE_WIDTH    = 16
) (
    input  logic                            clk_os,
    input  logic                            reset_os,
    input  logic                            i_start,
    input  logic                            i_pixel_valid,
    output logic                            o_wen,
    output logic [FIFO_COMPONENT_COUNT-1:0] o_ren,
    output logic [BYTE_DOUBLE_WIDTH-1:0]    o_xcoord,
    output logic [BYTE_DOUBLE_WIDTH-1:0]    o_ycoord,
    output logic                            o_window_valid,
    output logic                            o_busy,
    output logic                            o_frame_done
);

    localparam int RW = $clog2(FIFO_COMPONENT_COUNT + 1);

    localparam logic [BYTE_DOUBLE_WIDTH-1:0] X_LAST     = BYTE_DOUBLE_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BYTE_DOUBLE_WIDTH-1:0] Y_LAST     = BYTE_DOUBLE_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [BYTE_DOUBLE_WIDTH-1:0] Y_FILL_END = BYTE_DOUBLE_WIDTH'(FIFO_COMPONENT_COUNT - 2);
    localparam logic [BYTE_DOUBLE_WIDTH-1:0] WIN_EDGE   = BYTE_DOUBLE_WIDTH'(FIFO_COMPONENT_COUNT - 1);
    localparam logic [RW-1:0]                ROWS_MAX   = RW'(FIFO_COMPONENT_COUNT);

    if (FRAME_WIDTH > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("line_buffer_controller: FRAME_WIDTH exceeds 2**ADDR_WIDTH");
    end
    if (FIFO_COMPONENT_COUNT < 2) begin : g_bad_fifo_count
        $error("line_buffer_controller: FIFO_COMPONENT_COUNT must be at least 2");
    end
    if (FRAME_HEIGHT < FIFO_COMPONENT_COUNT) begin : g_bad_height
        $error("line_buffer_controller: FRAME_HEIGHT must be at least FIFO_COMPONENT_COUNT");
    end

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [BYTE_DOUBLE_WIDTH-1:0]   xcoord;
    logic [BYTE_DOUBLE_WIDTH-1:0]   ycoord;
    logic [RW-1:0]                  rows_filled;
    logic                           active;
    logic                           accept;
    logic                           row_end;

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept && row_end && (ycoord == Y_FILL_END)) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (accept && row_end && (ycoord == Y_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset masks every output so nothing leaks out during the reset cycle itself.
    always_comb begin
        active         = 1'b0;
        accept         = 1'b0;
        row_end        = 1'b0;
        o_ren          = '0;
        o_wen          = 1'b0;
        o_window_valid = 1'b0;
        o_busy         = 1'b0;
        o_frame_done   = 1'b0;
        o_xcoord       = '0;
        o_ycoord       = '0;
        if (!reset_os) begin
            active         = (state == FILL) || (state == STREAM);
            accept         = active && i_pixel_valid;
            row_end        = (xcoord == X_LAST);
            o_wen          = accept;
            o_busy         = active;
            o_frame_done   = (state == DONE);
            o_xcoord       = xcoord;
            o_ycoord       = ycoord;
            o_window_valid = accept && (ycoord >= WIN_EDGE) && (xcoord >= WIN_EDGE);
            for (int k = 0; k < FIFO_COMPONENT_COUNT; k++) begin
                o_ren[k] = accept && (rows_filled > RW'(k));
            end
        end
    end

    always_ff @(posedge clk_os) begin
        if (reset_os || (state == DONE)) begin
            xcoord      <= '0;
            ycoord      <= '0;
            rows_filled <= '0;
        end else if (accept) begin
            if (row_end) begin
                xcoord <= '0;
                ycoord <= ycoord + 1'b1;
                if (rows_filled != ROWS_MAX) begin
                    rows_filled <= rows_filled + 1'b1;
                end
            end else begin
                xcoord <= xcoord + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_controller.sv
// Self-checking bench for line_buffer_controller: directed frame scenarios plus random traffic,
// compared every cycle against a pixel-count model of the frame raster.
module tb_line_buffer_controller;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int F  = 6;
    localparam int BW = 16;

    logic          clk_os        = 1'b0;
    logic          reset_os      = 1'b1;
    logic          i_start       = 1'b0;
    logic          i_pixel_valid = 1'b0;
    logic          o_wen;
    logic [F-1:0]  o_ren;
    logic [BW-1:0] o_xcoord;
    logic [BW-1:0] o_ycoord;
    logic          o_window_valid;
    logic          o_busy;
    logic          o_frame_done;

    line_buffer_controller #(
        .FRAME_WIDTH(W),
        .FRAME_HEIGHT(H),
        .FIFO_COMPONENT_COUNT(F),
        .ADDR_WIDTH(4),
        .BYTE_DOUBLE_WIDTH(BW)
    ) dut (
        .clk_os(clk_os),
        .reset_os(reset_os),
        .i_start(i_start),
        .i_pixel_valid(i_pixel_valid),
        .o_wen(o_wen),
        .o_ren(o_ren),
        .o_xcoord(o_xcoord),
        .o_ycoord(o_ycoord),
        .o_window_valid(o_window_valid),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 clk_os = ~clk_os;

    // Model: a frame is just a count of accepted pixels; coordinates follow from div/mod.
    typedef enum {P_IDLE, P_ACTIVE, P_DONE} phase_t;
    phase_t phase = P_IDLE;
    int     n     = 0;

    int checks      = 0;
    int errors      = 0;
    int done_pulses = 0;
    int first_win   = -1;
    logic seen_ren0 = 1'b0;
    int ren0_x      = -1;
    int ren0_y      = -1;

    logic          s_wen;
    logic [F-1:0]  s_ren;
    logic [BW-1:0] s_x;
    logic [BW-1:0] s_y;
    logic          s_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input logic v, input logic r);
        logic         exp_busy;
        logic         acc;
        int           row;
        int           col;
        int           rows;
        logic [F-1:0] exp_ren;
        exp_busy = !r && (phase == P_ACTIVE);
        acc      = exp_busy && v;
        row      = r ? 0 : n / W;
        col      = r ? 0 : n % W;
        rows     = (row > F) ? F : row;
        for (int k = 0; k < F; k++) begin
            exp_ren[k] = acc && (rows > k);
        end
        s_wen  = o_wen;
        s_ren  = o_ren;
        s_x    = o_xcoord;
        s_y    = o_ycoord;
        s_done = o_frame_done;
        check("wen", 32'(o_wen), 32'(acc));
        check("ren", 32'(o_ren), 32'(exp_ren));
        check("xcoord", 32'(o_xcoord), 32'(col));
        check("ycoord", 32'(o_ycoord), 32'(row));
        check("window_valid", 32'(o_window_valid), 32'(acc && row >= F - 1 && col >= F - 1));
        check("busy", 32'(o_busy), 32'(exp_busy));
        check("frame_done", 32'(o_frame_done), 32'(!r && phase == P_DONE));
        if (o_window_valid && first_win < 0) first_win = n + 1;
        if (o_ren[0] && !seen_ren0) begin
            seen_ren0 = 1'b1;
            ren0_x    = int'(o_xcoord);
            ren0_y    = int'(o_ycoord);
        end
        if (o_frame_done) done_pulses++;
    endtask

    task automatic model_update(input logic v, input logic s, input logic r);
        if (r) begin
            phase = P_IDLE;
            n     = 0;
        end else begin
            case (phase)
                P_IDLE:   if (s) phase = P_ACTIVE;
                P_ACTIVE: if (v) begin
                    n++;
                    if (n == W * H) phase = P_DONE;
                end
                default: begin
                    phase = P_IDLE;
                    n     = 0;
                end
            endcase
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic r);
        @(negedge clk_os);
        i_pixel_valid = v;
        i_start       = s;
        reset_os      = r;
        #1;
        check_output(v, r);
        @(posedge clk_os);
        model_update(v, s, r);
    endtask

    initial begin
        int nb;
        int pulses_before;

        // Reset held with valid high: everything must stay quiet.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("idle_wen_after_reset", 32'(s_wen), 32'd0);

        // Frame 1: start, then continuous valid up to pixel (4,4).
        apply_stimulus(1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 44; p++) begin
            nb = n;
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (nb == 30) begin
                check("wrap_x_at_0_3", 32'(s_x), 32'd0);
                check("wrap_y_at_0_3", 32'(s_y), 32'd3);
                check("ren_at_0_3", 32'(s_ren), 32'b000111);
            end
        end

        // Bubbles at (4,4).
        for (int b = 0; b < 3; b++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
            check("bubble_wen", 32'(s_wen), 32'd0);
            check("bubble_x", 32'(s_x), 32'd4);
            check("bubble_y", 32'(s_y), 32'd4);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("resume_wen", 32'(s_wen), 32'd1);
        check("resume_x", 32'(s_x), 32'd4);
        check("resume_y", 32'(s_y), 32'd4);

        // Run to pixel 99, then last pixel with a coincident start.
        for (int p = 0; p < 200 && n < W * H - 1; p++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check("last_pixel_wen", 32'(s_wen), 32'd1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check("frame_done_pulse", 32'(s_done), 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("post_frame_wen", 32'(s_wen), 32'd0);
        check("post_frame_done", 32'(s_done), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("frame1_done_count", 32'(done_pulses), 32'd1);
        check("first_window_pixel", 32'(first_win), 32'd56);
        check("first_ren0_x", 32'(ren0_x), 32'd0);
        check("first_ren0_y", 32'(ren0_y), 32'd1);

        // Abort: reset at the 37th pixel.
        pulses_before = done_pulses;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 36; p++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check("abort_wen", 32'(s_wen), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("restart_x", 32'(s_x), 32'd0);
        check("restart_y", 32'(s_y), 32'd0);
        check("restart_ren", 32'(s_ren), 32'd0);
        check("restart_wen", 32'(s_wen), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("abort_no_done", 32'(done_pulses), 32'(pulses_before));

        // Random traffic: bubbles, stray starts and occasional aborts.
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus($urandom_range(0, 3) != 0,
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
